// File: rtl/alien_pkg.sv
// Shared types and defaults for the alien fleet: sequencer states, the frozen
// movement period and the default screen bounds and timing constants.
package alien_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MARCH   = 2'd1,
    DESCEND = 2'd2,
    CLEARED = 2'd3
  } fleet_state_t;

  localparam int X_W    = 10;
  localparam int FREQ_W = 16;

  localparam logic [FREQ_W-1:0] FREQ_FROZEN = 16'hFFFF;

  localparam logic [X_W-1:0]    SCREEN_LEFT_DEF   = 10'd16;
  localparam logic [X_W-1:0]    SCREEN_RIGHT_DEF  = 10'd623;
  localparam logic [FREQ_W-1:0] BASE_PERIOD_DEF   = 16'd2000;
  localparam logic [FREQ_W-1:0] PERIOD_STEP_DEF   = 16'd100;
  localparam logic [FREQ_W-1:0] MIN_PERIOD_DEF    = 16'd200;
  localparam logic [FREQ_W-1:0] FIRE_INTERVAL_DEF = 16'd5000;

endpackage

// File: rtl/alien_fleet_controller_if.sv
// Fleet-side bundle: per-alien status flowing in, shared movement and fire
// grants flowing out. The controller is the master, the alien array the slave.
interface alien_fleet_controller_if
  import alien_pkg::*;
#(
  parameter int NUM_ALIENS = 8
);

  logic [NUM_ALIENS-1:0] alive;
  logic [X_W-1:0]        fleet_min_x;
  logic [X_W-1:0]        fleet_max_x;
  logic [FREQ_W-1:0]     movement_frequency;
  logic                  movement_direction;
  logic                  step_down;
  logic [NUM_ALIENS-1:0] armed;

  modport master (
    input  alive, fleet_min_x, fleet_max_x,
    output movement_frequency, movement_direction, step_down, armed
  );

  modport slave (
    output alive, fleet_min_x, fleet_max_x,
    input  movement_frequency, movement_direction, step_down, armed
  );

endinterface

// File: rtl/alien_rr_picker.sv
// Round-robin fire picker: finds the first alive alien strictly after ptr,
// wrapping around, and returns it as a one-hot grant plus its index.
module alien_rr_picker #(
  parameter int NUM_ALIENS = 8,
  parameter int PTR_W      = $clog2(NUM_ALIENS)
) (
  input  logic [NUM_ALIENS-1:0] alive,
  input  logic [PTR_W-1:0]      ptr,
  output logic [NUM_ALIENS-1:0] grant,
  output logic [PTR_W-1:0]      next_idx
);

  logic             found;
  logic [PTR_W-1:0] cand;

  // i runs 1..NUM_ALIENS so the pointer itself is considered last
  always_comb begin
    grant    = '0;
    next_idx = ptr;
    found    = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NUM_ALIENS; i++) begin
      cand = PTR_W'((int'(ptr) + i) % NUM_ALIENS);
      if (!found && alive[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        next_idx    = cand;
      end
    end
  end

endmodule

// File: rtl/alien_fleet_controller.sv
// Fleet sequencer: marches the fleet side to side, steps it down and speeds it
// up at each screen edge, and hands out round-robin fire grants to living aliens.
module alien_fleet_controller
  import alien_pkg::*;
#(
  parameter int                NUM_ALIENS    = 8,
  parameter logic [X_W-1:0]    SCREEN_LEFT   = SCREEN_LEFT_DEF,
  parameter logic [X_W-1:0]    SCREEN_RIGHT  = SCREEN_RIGHT_DEF,
  parameter logic [FREQ_W-1:0] BASE_PERIOD   = BASE_PERIOD_DEF,
  parameter logic [FREQ_W-1:0] PERIOD_STEP   = PERIOD_STEP_DEF,
  parameter logic [FREQ_W-1:0] MIN_PERIOD    = MIN_PERIOD_DEF,
  parameter logic [FREQ_W-1:0] FIRE_INTERVAL = FIRE_INTERVAL_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  alien_fleet_controller_if.master fleet,
  output logic                     wave_cleared
);

  localparam int PTR_W = $clog2(NUM_ALIENS);
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_ALIENS - 1);

  fleet_state_t          state_q, state_d;
  logic [FREQ_W-1:0]     freq_q, freq_d;
  logic                  dir_q, dir_d;
  logic                  step_q, step_d;
  logic [NUM_ALIENS-1:0] armed_q, armed_d;
  logic                  cleared_q, cleared_d;
  logic [FREQ_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;

  logic                  any_alive;
  logic                  edge_hit;
  logic [NUM_ALIENS-1:0] rr_grant;
  logic [PTR_W-1:0]      rr_next;

  // Sum is widened so large MIN_PERIOD + PERIOD_STEP cannot wrap
  function automatic logic [FREQ_W-1:0] faster_period(input logic [FREQ_W-1:0] f);
    logic [FREQ_W:0] thresh;
    thresh = {1'b0, MIN_PERIOD} + {1'b0, PERIOD_STEP};
    if ({1'b0, f} > thresh) return f - PERIOD_STEP;
    else                    return MIN_PERIOD;
  endfunction

  alien_rr_picker #(
    .NUM_ALIENS (NUM_ALIENS),
    .PTR_W      (PTR_W)
  ) u_rr_picker (
    .alive    (fleet.alive),
    .ptr      (ptr_q),
    .grant    (rr_grant),
    .next_idx (rr_next)
  );

  assign any_alive = |fleet.alive;
  // Only the edge ahead of the fleet counts, so a just-reversed fleet can't re-trigger
  assign edge_hit  = dir_q ? (fleet.fleet_max_x >= SCREEN_RIGHT)
                           : (fleet.fleet_min_x <= SCREEN_LEFT);

  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    armed_d = '0;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;

    case (state_q)
      IDLE, CLEARED: begin
        freq_d = FREQ_FROZEN;
        cnt_d  = '0;
        if (start) begin
          state_d = MARCH;
          freq_d  = BASE_PERIOD;
          dir_d   = 1'b1;
          ptr_d   = PTR_INIT;
        end
      end
      MARCH: begin
        if (!any_alive) begin
          state_d = CLEARED;
          freq_d  = FREQ_FROZEN;
        end else if (edge_hit) begin
          state_d = DESCEND;
          step_d  = 1'b1;
          dir_d   = !dir_q;
          freq_d  = faster_period(freq_q);
        end
      end
      DESCEND: begin
        if (!any_alive) begin
          state_d = CLEARED;
          freq_d  = FREQ_FROZEN;
        end else begin
          state_d = MARCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q == MARCH || state_q == DESCEND) begin
      if (cnt_q == FIRE_INTERVAL - 16'd1) begin
        cnt_d = '0;
        if (any_alive) begin
          armed_d = rr_grant;
          ptr_d   = rr_next;
        end
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    if (state_d == CLEARED) cnt_d = '0;
    cleared_d = (state_d == CLEARED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      freq_q    <= FREQ_FROZEN;
      dir_q     <= 1'b1;
      step_q    <= 1'b0;
      armed_q   <= '0;
      cleared_q <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= PTR_INIT;
    end else begin
      state_q   <= state_d;
      freq_q    <= freq_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      armed_q   <= armed_d;
      cleared_q <= cleared_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  assign fleet.movement_frequency = freq_q;
  assign fleet.movement_direction = dir_q;
  assign fleet.step_down          = step_q;
  assign fleet.armed              = armed_q;
  assign wave_cleared             = cleared_q;

endmodule

// File: tb/tb_alien_fleet_controller.sv
// Directed bench for alien_fleet_controller: three instances cover default
// marching, a short fire interval with period floor, and a one-cycle fire interval.
module tb_alien_fleet_controller;
  import alien_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b, start_c;
  logic wc_a, wc_b, wc_c;

  int tests = 0;
  int fails = 0;
  logic dir_a;

  alien_fleet_controller_if #(.NUM_ALIENS(8)) if_a ();
  alien_fleet_controller_if #(.NUM_ALIENS(8)) if_b ();
  alien_fleet_controller_if #(.NUM_ALIENS(8)) if_c ();

  alien_fleet_controller dut_a (
    .clk (clk), .rst_n (rst_n), .start (start_a), .fleet (if_a), .wave_cleared (wc_a)
  );

  alien_fleet_controller #(
    .BASE_PERIOD (16'd450), .FIRE_INTERVAL (16'd4)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .start (start_b), .fleet (if_b), .wave_cleared (wc_b)
  );

  alien_fleet_controller #(
    .FIRE_INTERVAL (16'd1)
  ) dut_c (
    .clk (clk), .rst_n (rst_n), .start (start_c), .fleet (if_c), .wave_cleared (wc_c)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Touch the edge ahead of fleet A, check the pulse, hold the edge, then release
  task automatic bounce_a(input logic [15:0] exp_freq);
    if (dir_a) if_a.fleet_max_x = 10'd623;
    else       if_a.fleet_min_x = 10'd16;
    tick();
    check("a_step_pulse", 32'(if_a.step_down), 32'd1);
    check("a_dir_flip", 32'(if_a.movement_direction), 32'(!dir_a));
    check("a_freq", 32'(if_a.movement_frequency), 32'(exp_freq));
    dir_a = !dir_a;
    tick();
    check("a_step_low_descend", 32'(if_a.step_down), 32'd0);
    tick();
    check("a_step_no_retrigger", 32'(if_a.step_down), 32'd0);
    if_a.fleet_max_x = 10'd300;
    if_a.fleet_min_x = 10'd300;
    tick();
  endtask

  logic [7:0]  exp_b_armed [4] = '{8'h04, 8'h20, 8'h80, 8'h04};
  logic [15:0] exp_b_freq  [4] = '{16'd350, 16'd250, 16'd200, 16'd200};

  initial begin
    logic dir_b;
    rst_n   = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    if_a.alive = 8'hFF;        if_a.fleet_min_x = 10'd300; if_a.fleet_max_x = 10'd300;
    if_b.alive = 8'b1010_0100; if_b.fleet_min_x = 10'd300; if_b.fleet_max_x = 10'd300;
    if_c.alive = 8'h81;        if_c.fleet_min_x = 10'd300; if_c.fleet_max_x = 10'd300;
    tick();
    tick();
    check("rst_freq", 32'(if_a.movement_frequency), 32'hFFFF);
    check("rst_dir", 32'(if_a.movement_direction), 32'd1);
    check("rst_step", 32'(if_a.step_down), 32'd0);
    check("rst_armed", 32'(if_a.armed), 32'd0);
    check("rst_cleared", 32'(wc_a), 32'd0);
    check("rst_state", 32'(dut_a.state_q), 32'(IDLE));
    rst_n = 1'b1;
    tick();
    check("idle_freq_frozen", 32'(if_a.movement_frequency), 32'hFFFF);

    // Fleet A: start, bounce right then left, then walk the period to its floor
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("start_state", 32'(dut_a.state_q), 32'(MARCH));
    check("start_freq", 32'(if_a.movement_frequency), 32'd2000);
    check("start_dir", 32'(if_a.movement_direction), 32'd1);
    check("start_armed", 32'(if_a.armed), 32'd0);
    check("start_cleared", 32'(wc_a), 32'd0);
    dir_a = 1'b1;
    bounce_a(16'd1900);
    bounce_a(16'd1800);
    for (int f = 1700; f >= 300; f -= 100) bounce_a(16'(f));
    bounce_a(16'd200);
    bounce_a(16'd200);
    bounce_a(16'd200);
    check("a_dir_before_clear", 32'(if_a.movement_direction), 32'd1);

    // Clear wins over a simultaneous right-edge hit
    if_a.alive = 8'h00;
    if_a.fleet_max_x = 10'd623;
    tick();
    check("clear_cleared", 32'(wc_a), 32'd1);
    check("clear_no_step", 32'(if_a.step_down), 32'd0);
    check("clear_freq", 32'(if_a.movement_frequency), 32'hFFFF);
    check("clear_state", 32'(dut_a.state_q), 32'(CLEARED));
    tick();
    check("clear_hold", 32'(wc_a), 32'd1);
    check("clear_armed", 32'(if_a.armed), 32'd0);
    if_a.alive = 8'hFF;
    if_a.fleet_max_x = 10'd300;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("restart_freq", 32'(if_a.movement_frequency), 32'd2000);
    check("restart_cleared", 32'(wc_a), 32'd0);
    check("restart_dir", 32'(if_a.movement_direction), 32'd1);

    // Fleet B: round-robin grants every 4 cycles, each one cycle wide
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_start_freq", 32'(if_b.movement_frequency), 32'd450);
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        check("b_armed_gap", 32'(if_b.armed), 32'd0);
      end
      tick();
      check("b_armed_grant", 32'(if_b.armed), 32'(exp_b_armed[g]));
    end

    // Fleet B: period floors at MIN_PERIOD and stays there
    dir_b = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (dir_b) if_b.fleet_max_x = 10'd623;
      else       if_b.fleet_min_x = 10'd16;
      tick();
      check("b_floor_step", 32'(if_b.step_down), 32'd1);
      check("b_floor_freq", 32'(if_b.movement_frequency), 32'(exp_b_freq[j]));
      dir_b = !dir_b;
      if_b.fleet_max_x = 10'd300;
      if_b.fleet_min_x = 10'd300;
      tick();
      tick();
    end

    // Fleet C: a grant every cycle, coinciding with an edge event
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    check("c_armed_pre", 32'(if_c.armed), 32'd0);
    tick();
    check("c_armed_0", 32'(if_c.armed), 32'h01);
    if_c.fleet_max_x = 10'd623;
    tick();
    check("c_armed_1", 32'(if_c.armed), 32'h80);
    check("c_step_with_grant", 32'(if_c.step_down), 32'd1);
    check("c_freq", 32'(if_c.movement_frequency), 32'd1900);
    if_c.fleet_max_x = 10'd300;
    tick();
    check("c_armed_2", 32'(if_c.armed), 32'h01);

    // Reset asserted while fleet A is in DESCEND takes effect without a clock edge
    if_a.fleet_max_x = 10'd623;
    tick();
    check("pre_rst_step", 32'(if_a.step_down), 32'd1);
    check("pre_rst_state", 32'(dut_a.state_q), 32'(DESCEND));
    rst_n = 1'b0;
    #2;
    check("async_rst_step", 32'(if_a.step_down), 32'd0);
    check("async_rst_freq", 32'(if_a.movement_frequency), 32'hFFFF);
    check("async_rst_dir", 32'(if_a.movement_direction), 32'd1);
    check("async_rst_state", 32'(dut_a.state_q), 32'(IDLE));
    check("async_rst_cleared", 32'(wc_a), 32'd0);
    check("async_rst_armed_c", 32'(if_c.armed), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alien_fleet_controller.md
# alien_fleet_controller

Sequences a fleet of `alien` instances. It owns the shared `movement_direction` and `movement_frequency` fed to every alien, and detects when the fleet reaches a screen edge. At each edge it issues a one-cycle step-down, reverses direction and speeds the fleet up. It also schedules firing by granting `armed` to one living alien at a time in round-robin order. It sits between the alien array and the game-level state logic.

## Interface
- `NUM_ALIENS`, 8, number of aliens under control (2..32).
- `SCREEN_LEFT`, 10'd16, leftmost legal x; an edge is reached when `fleet_min_x <= SCREEN_LEFT`.
- `SCREEN_RIGHT`, 10'd623, rightmost legal x; an edge is reached when `fleet_max_x >= SCREEN_RIGHT`.
- `BASE_PERIOD`, 16'd2000, movement period at wave start.
- `PERIOD_STEP`, 16'd100, period reduction per edge bounce.
- `MIN_PERIOD`, 16'd200, floor for the movement period.
- `FIRE_INTERVAL`, 16'd5000, cycles between fire grants; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a wave; accepted only in IDLE or CLEARED.
- `alive`  in  NUM_ALIENS  per-alien alive mask.
- `fleet_min_x`  in  10  leftmost x of the living aliens; valid whenever `alive != 0`.
- `fleet_max_x`  in  10  rightmost x of the living aliens.
- `movement_frequency`  out  16  period broadcast to all aliens.
- `movement_direction`  out  1  direction broadcast to all aliens: 0 = left, 1 = right.
- `step_down`  out  1  one-cycle pulse; the y-update logic lowers the fleet one row on it.
- `armed`  out  NUM_ALIENS  one-hot fire grant, high for one cycle, or all zero.
- `wave_cleared`  out  1  level, high while in CLEARED.

## Operation
- States: IDLE, MARCH, DESCEND, CLEARED.
- **IDLE** (reset state):
  - `movement_frequency` = 16'hFFFF (fleet effectively frozen); `armed` = 0.
  - `start` → MARCH, with `movement_frequency` = BASE_PERIOD, direction = 1, fire counter = 0, RR pointer = NUM_ALIENS-1.
- **MARCH**, priority order:
  - `alive == 0` → CLEARED.
  - else direction = 1 and `fleet_max_x >= SCREEN_RIGHT` → DESCEND.
  - else direction = 0 and `fleet_min_x <= SCREEN_LEFT` → DESCEND.
  - Only the edge in the current direction is checked, so a fleet still touching the edge after reversal does not re-trigger.
- **On entry to DESCEND**, all registered at the same clock edge:
  - `step_down` = 1.
  - direction toggles.
  - `movement_frequency` = (freq > MIN_PERIOD + PERIOD_STEP) ? freq − PERIOD_STEP : MIN_PERIOD. The sum is computed 17 bits wide; no wrap.
- **DESCEND** lasts exactly one cycle, then returns to MARCH (or CLEARED if `alive == 0`). No edge check is made in DESCEND.
- **CLEARED**:
  - `wave_cleared` = 1; `movement_frequency` = 16'hFFFF; `armed` = 0.
  - `start` → MARCH with the same initialisation as from IDLE.
- `start` is ignored in MARCH and DESCEND.
- **Fire scheduler** (active in MARCH and DESCEND only):
  - 16-bit counter counts up.
  - When the counter equals FIRE_INTERVAL−1: counter → 0, and if `alive != 0`, `armed` is asserted next cycle, one-hot at the first alive index strictly after the pointer (wrapping modulo NUM_ALIENS). The pointer is updated to that index.
  - If `alive == 0` at expiry, no grant is made and the pointer is unchanged.
  - The counter is held at 0 in IDLE and CLEARED.

## Timing
- Reset values: state IDLE, `movement_frequency` 16'hFFFF, `movement_direction` 1, `step_down` 0, `armed` 0, `wave_cleared` 0, counter 0, pointer NUM_ALIENS-1.
- Reset asserted mid-wave returns every register to these values immediately.
- All outputs are registered; there is no combinational input→output path.
- Edge sampled at cycle t → `step_down`, new direction and new frequency are all visible at t+1. `step_down` is low at t+2.
- `start` at cycle t → state MARCH and `movement_frequency` = BASE_PERIOD at t+1.
- `alive` goes to 0 at t → `wave_cleared` = 1 at t+1. A clear takes priority over a simultaneous edge (no `step_down`).
- Grants occur every FIRE_INTERVAL cycles. An edge event and a fire grant in the same cycle are independent; both occur.
- With FIRE_INTERVAL = 1, a grant is made every cycle.

## Structure
- Shared `alien_pkg`:
  - `fleet_state_t` enum (IDLE, MARCH, DESCEND, CLEARED).
  - `FREQ_FROZEN` = 16'hFFFF.
  - Screen-bound defaults.
- Sub-module `alien_rr_picker`: combinational. Takes `alive` and the pointer; returns a one-hot grant and the next index. It is parameterised by NUM_ALIENS and instantiated once.

## Test plan
- Reset, then `start` → at t+1: MARCH, freq = 2000, dir = 1, `armed` = 0, `wave_cleared` = 0.
- `fleet_max_x` driven to 623 in MARCH → one `step_down` pulse; dir = 0; freq = 1900. Holding 623 afterwards gives no further pulse. `fleet_min_x` = 16 then bounces the fleet back to dir = 1 with freq = 1800.
- Repeated bounces from freq = 250 → next value is 200 (floor), and it stays at 200 on further bounces.
- `alive` = 8'b1010_0100, FIRE_INTERVAL = 4 → `armed` sequence 8'h04, 8'h20, 8'h80, 8'h04, one grant every 4 cycles, each one cycle wide.
- `alive` → 0 in the same cycle `fleet_max_x` ≥ 623 → CLEARED, no `step_down`, freq = FFFF; a later `start` restarts at freq = 2000.
- `rst_n` asserted during DESCEND → `step_down` = 0, IDLE, and all outputs at reset values without waiting for a clock edge.
